// File: rtl/id_ex_issue_if.sv
// Decode-to-execute issue bus: decoded instruction in, E-stage register contents out.
interface id_ex_issue_if;
    logic        valid_i;
    logic        ready_o;
    logic [4:0]  rs1_addr_i;
    logic [4:0]  rs2_addr_i;
    logic [4:0]  rd_addr_i;
    logic [31:0] rs1_data_i;
    logic [31:0] rs2_data_i;
    logic [31:0] imm_i;
    logic [4:0]  alu_op_i;
    logic        use_imm_i;
    logic        rd_we_i;
    logic        is_load_i;
    logic        flush_i;

    logic        valid_o;
    logic [31:0] rs1_o;
    logic [31:0] rs2_o;
    logic [31:0] imm_o;
    logic [4:0]  alu_op_o;
    logic [1:0]  mux1_o;
    logic [1:0]  mux2_o;
    logic        mux3_o;
    logic [4:0]  rd_o;
    logic        rd_we_o;
    logic [15:0] stall_cnt_o;

    modport master (
        output valid_i, rs1_addr_i, rs2_addr_i, rd_addr_i, rs1_data_i, rs2_data_i,
               imm_i, alu_op_i, use_imm_i, rd_we_i, is_load_i, flush_i,
        input  ready_o, valid_o, rs1_o, rs2_o, imm_o, alu_op_o, mux1_o, mux2_o,
               mux3_o, rd_o, rd_we_o, stall_cnt_o
    );

    modport slave (
        input  valid_i, rs1_addr_i, rs2_addr_i, rd_addr_i, rs1_data_i, rs2_data_i,
               imm_i, alu_op_i, use_imm_i, rd_we_i, is_load_i, flush_i,
        output ready_o, valid_o, rs1_o, rs2_o, imm_o, alu_op_o, mux1_o, mux2_o,
               mux3_o, rd_o, rd_we_o, stall_cnt_o
    );
endinterface

// File: rtl/id_ex_issue.sv
// ID/EX issue register with EX/MEM and MEM/WB forwarding selects and a
// one-bubble load-use interlock; tracks E/M/W destination info internally.
module id_ex_issue (
    input  logic         clk_25mhz,
    input  logic         rst_n,
    id_ex_issue_if.slave bus
);

    typedef enum logic [1:0] {
        SEL_REG   = 2'b00,
        SEL_MEMWB = 2'b01,
        SEL_EXMEM = 2'b10
    } fwd_sel_e;

    // E stage (output register)
    logic        e_valid_q,   e_valid_d;
    logic [4:0]  e_rd_q,      e_rd_d;
    logic        e_rd_we_q,   e_rd_we_d;
    logic        e_is_load_q, e_is_load_d;
    logic [31:0] e_rs1_q,     e_rs1_d;
    logic [31:0] e_rs2_q,     e_rs2_d;
    logic [31:0] e_imm_q,     e_imm_d;
    logic [4:0]  e_alu_op_q,  e_alu_op_d;
    fwd_sel_e    e_mux1_q,    e_mux1_d;
    fwd_sel_e    e_mux2_q,    e_mux2_d;
    logic        e_mux3_q,    e_mux3_d;

    // M and W stages
    logic        m_valid_q, m_rd_we_q, m_is_load_q;
    logic [4:0]  m_rd_q;
    logic        w_valid_q, w_rd_we_q, w_is_load_q;
    logic [4:0]  w_rd_q;

    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic e_hit_rs1, e_hit_rs2, m_hit_rs1, m_hit_rs2;
    logic hazard, ready, accept;

    always_comb begin
        e_hit_rs1 = e_valid_q & e_rd_we_q & (e_rd_q != '0) & (e_rd_q == bus.rs1_addr_i);
        e_hit_rs2 = e_valid_q & e_rd_we_q & (e_rd_q != '0) & (e_rd_q == bus.rs2_addr_i);
        m_hit_rs1 = m_valid_q & m_rd_we_q & (m_rd_q != '0) & (m_rd_q == bus.rs1_addr_i);
        m_hit_rs2 = m_valid_q & m_rd_we_q & (m_rd_q != '0) & (m_rd_q == bus.rs2_addr_i);
        // A load in E has no value to forward yet; the consumer must wait one cycle.
        hazard = bus.valid_i & e_is_load_q & (e_hit_rs1 | (e_hit_rs2 & ~bus.use_imm_i));
        ready  = ~hazard & ~bus.flush_i & rst_n;
        accept = bus.valid_i & ready;
    end

    always_comb begin
        e_valid_d   = 1'b0;
        e_rd_d      = '0;
        e_rd_we_d   = 1'b0;
        e_is_load_d = 1'b0;
        e_rs1_d     = '0;
        e_rs2_d     = '0;
        e_imm_d     = '0;
        e_alu_op_d  = '0;
        e_mux1_d    = SEL_REG;
        e_mux2_d    = SEL_REG;
        e_mux3_d    = 1'b0;
        if (accept) begin
            e_valid_d   = 1'b1;
            e_rd_d      = bus.rd_addr_i;
            e_rd_we_d   = bus.rd_we_i;
            e_is_load_d = bus.is_load_i;
            e_rs1_d     = bus.rs1_data_i;
            e_rs2_d     = bus.rs2_data_i;
            e_imm_d     = bus.imm_i;
            e_alu_op_d  = bus.alu_op_i;
            e_mux3_d    = bus.use_imm_i;
            if (e_hit_rs1)      e_mux1_d = SEL_EXMEM;
            else if (m_hit_rs1) e_mux1_d = SEL_MEMWB;
            if (!bus.use_imm_i) begin
                if (e_hit_rs2)      e_mux2_d = SEL_EXMEM;
                else if (m_hit_rs2) e_mux2_d = SEL_MEMWB;
            end
        end
    end

    // A flushed stall is not counted: the stalled instruction is being discarded.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hazard && !bus.flush_i && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            e_valid_q   <= 1'b0;
            e_rd_q      <= '0;
            e_rd_we_q   <= 1'b0;
            e_is_load_q <= 1'b0;
            e_rs1_q     <= '0;
            e_rs2_q     <= '0;
            e_imm_q     <= '0;
            e_alu_op_q  <= '0;
            e_mux1_q    <= SEL_REG;
            e_mux2_q    <= SEL_REG;
            e_mux3_q    <= 1'b0;
            m_valid_q   <= 1'b0;
            m_rd_q      <= '0;
            m_rd_we_q   <= 1'b0;
            m_is_load_q <= 1'b0;
            w_valid_q   <= 1'b0;
            w_rd_q      <= '0;
            w_rd_we_q   <= 1'b0;
            w_is_load_q <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            e_valid_q   <= e_valid_d;
            e_rd_q      <= e_rd_d;
            e_rd_we_q   <= e_rd_we_d;
            e_is_load_q <= e_is_load_d;
            e_rs1_q     <= e_rs1_d;
            e_rs2_q     <= e_rs2_d;
            e_imm_q     <= e_imm_d;
            e_alu_op_q  <= e_alu_op_d;
            e_mux1_q    <= e_mux1_d;
            e_mux2_q    <= e_mux2_d;
            e_mux3_q    <= e_mux3_d;
            m_valid_q   <= e_valid_q;
            m_rd_q      <= e_rd_q;
            m_rd_we_q   <= e_rd_we_q;
            m_is_load_q <= e_is_load_q;
            w_valid_q   <= m_valid_q;
            w_rd_q      <= m_rd_q;
            w_rd_we_q   <= m_rd_we_q;
            w_is_load_q <= m_is_load_q;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // W is tracked for visibility only; the register file handles write-through.
    logic unused_wb;
    assign unused_wb = ^{w_valid_q, w_rd_q, w_rd_we_q, w_is_load_q, m_is_load_q};

    assign bus.ready_o     = ready;
    assign bus.valid_o     = e_valid_q;
    assign bus.rs1_o       = e_rs1_q;
    assign bus.rs2_o       = e_rs2_q;
    assign bus.imm_o       = e_imm_q;
    assign bus.alu_op_o    = e_alu_op_q;
    assign bus.mux1_o      = e_mux1_q;
    assign bus.mux2_o      = e_mux2_q;
    assign bus.mux3_o      = e_mux3_q;
    assign bus.rd_o        = e_rd_q;
    assign bus.rd_we_o     = e_rd_we_q;
    assign bus.stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_issue.sv
// Directed bench for id_ex_issue: forwarding selects, load-use stall, flush,
// x0/immediate handling, stall counter saturation and asynchronous reset.
module tb_id_ex_issue;

    logic clk_25mhz = 1'b0;
    logic rst_n     = 1'b0;
    int   checks    = 0;
    int   errors    = 0;

    id_ex_issue_if bus ();

    id_ex_issue dut (
        .clk_25mhz (clk_25mhz),
        .rst_n     (rst_n),
        .bus       (bus)
    );

    always #20 clk_25mhz = ~clk_25mhz;

    task automatic tick;
        @(posedge clk_25mhz);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [4:0] op, input logic use_imm,
                         input logic we, input logic ld, input logic [31:0] imm);
        bus.valid_i    = v;
        bus.rs1_addr_i = rs1;
        bus.rs2_addr_i = rs2;
        bus.rd_addr_i  = rd;
        bus.rs1_data_i = 32'hA000_0000 | 32'(rs1);
        bus.rs2_data_i = 32'hB000_0000 | 32'(rs2);
        bus.imm_i      = imm;
        bus.alu_op_i   = op;
        bus.use_imm_i  = use_imm;
        bus.rd_we_i    = we;
        bus.is_load_i  = ld;
        #1;
    endtask

    task automatic idle;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        tick();
    endtask

    task automatic test_reset;
        bus.flush_i = 1'b0;
        drive(1'b1, 5'd1, 5'd2, 5'd3, 5'd1, 1'b0, 1'b1, 1'b0, 32'h0);
        repeat (3) @(negedge clk_25mhz);
        checks++; if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready got %0b want 0", bus.ready_o); end
        checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b want 0", bus.valid_o); end
        checks++; if (bus.stall_cnt_o !== 16'h0) begin errors++; $display("FAIL rst_cnt got %0h want 0", bus.stall_cnt_o); end
        checks++; if (bus.mux1_o !== 2'b00 || bus.mux2_o !== 2'b00) begin errors++; $display("FAIL rst_mux got %0b/%0b want 00/00", bus.mux1_o, bus.mux2_o); end
        rst_n = 1'b1;
        #1;
        idle();
    endtask

    task automatic test_ex_forward;
        drive(1'b1, 5'd1, 5'd2, 5'd3, 5'd1, 1'b0, 1'b1, 1'b0, 32'h0);
        checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL add_ready got %0b want 1", bus.ready_o); end
        tick();
        checks++; if (bus.valid_o !== 1'b1 || bus.rd_o !== 5'd3 || bus.alu_op_o !== 5'd1) begin errors++; $display("FAIL add_issue got v%0b rd%0d op%0d want v1 rd3 op1", bus.valid_o, bus.rd_o, bus.alu_op_o); end
        checks++; if (bus.rs1_o !== 32'hA000_0001 || bus.rs2_o !== 32'hB000_0002) begin errors++; $display("FAIL add_data got %0h/%0h want a0000001/b0000002", bus.rs1_o, bus.rs2_o); end
        drive(1'b1, 5'd3, 5'd4, 5'd6, 5'd2, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        checks++; if (bus.mux1_o !== 2'b10) begin errors++; $display("FAIL sub_mux1 got %0b want 10", bus.mux1_o); end
        checks++; if (bus.mux2_o !== 2'b00) begin errors++; $display("FAIL sub_mux2 got %0b want 00", bus.mux2_o); end
    endtask

    task automatic test_mem_forward;
        drive(1'b1, 5'd1, 5'd2, 5'd7, 5'd1, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        drive(1'b1, 5'd1, 5'd2, 5'd8, 5'd1, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        drive(1'b1, 5'd9, 5'd7, 5'd14, 5'd1, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        checks++; if (bus.mux2_o !== 2'b01) begin errors++; $display("FAIL wb_mux2 got %0b want 01", bus.mux2_o); end
        checks++; if (bus.mux1_o !== 2'b00) begin errors++; $display("FAIL wb_mux1 got %0b want 00", bus.mux1_o); end
        drive(1'b1, 5'd1, 5'd2, 5'd10, 5'd1, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        tick();
        drive(1'b1, 5'd10, 5'd2, 5'd15, 5'd1, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        checks++; if (bus.mux1_o !== 2'b10) begin errors++; $display("FAIL prio_mux1 got %0b want 10", bus.mux1_o); end
    endtask

    task automatic test_load_use;
        idle();
        drive(1'b1, 5'd1, 5'd0, 5'd5, 5'd8, 1'b1, 1'b1, 1'b1, 32'h10);
        tick();
        drive(1'b1, 5'd5, 5'd2, 5'd11, 5'd1, 1'b0, 1'b1, 1'b0, 32'h0);
        checks++; if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL lu_ready got %0b want 0", bus.ready_o); end
        tick();
        checks++; if (bus.valid_o !== 1'b0 || bus.alu_op_o !== 5'd0 || bus.rd_o !== 5'd0 || bus.rd_we_o !== 1'b0) begin errors++; $display("FAIL lu_bubble got v%0b op%0d rd%0d we%0b want all 0", bus.valid_o, bus.alu_op_o, bus.rd_o, bus.rd_we_o); end
        checks++; if (bus.rs1_o !== 32'h0 || bus.mux1_o !== 2'b00) begin errors++; $display("FAIL lu_bubble_data got %0h/%0b want 0/00", bus.rs1_o, bus.mux1_o); end
        checks++; if (bus.stall_cnt_o !== 16'd1) begin errors++; $display("FAIL lu_cnt got %0d want 1", bus.stall_cnt_o); end
        checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL lu_ready2 got %0b want 1", bus.ready_o); end
        tick();
        checks++; if (bus.valid_o !== 1'b1 || bus.rd_o !== 5'd11) begin errors++; $display("FAIL lu_issue got v%0b rd%0d want v1 rd11", bus.valid_o, bus.rd_o); end
        checks++; if (bus.mux1_o !== 2'b01) begin errors++; $display("FAIL lu_mux1 got %0b want 01", bus.mux1_o); end
        checks++; if (bus.stall_cnt_o !== 16'd1) begin errors++; $display("FAIL lu_cnt2 got %0d want 1", bus.stall_cnt_o); end
    endtask

    task automatic test_x0_imm;
        drive(1'b1, 5'd1, 5'd2, 5'd0, 5'd1, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        drive(1'b1, 5'd0, 5'd0, 5'd16, 5'd1, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        checks++; if (bus.mux1_o !== 2'b00 || bus.mux2_o !== 2'b00) begin errors++; $display("FAIL x0_mux got %0b/%0b want 00/00", bus.mux1_o, bus.mux2_o); end
        idle();
        drive(1'b1, 5'd1, 5'd0, 5'd12, 5'd8, 1'b1, 1'b1, 1'b1, 32'h4);
        tick();
        drive(1'b1, 5'd1, 5'd12, 5'd17, 5'd3, 1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF);
        checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL imm_ready got %0b want 1", bus.ready_o); end
        tick();
        checks++; if (bus.mux2_o !== 2'b00 || bus.mux3_o !== 1'b1) begin errors++; $display("FAIL imm_mux got %0b/%0b want 00/1", bus.mux2_o, bus.mux3_o); end
        checks++; if (bus.imm_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL imm_val got %0h want deadbeef", bus.imm_o); end
    endtask

    task automatic test_flush;
        idle();
        drive(1'b1, 5'd1, 5'd0, 5'd5, 5'd8, 1'b1, 1'b1, 1'b1, 32'h0);
        tick();
        drive(1'b1, 5'd5, 5'd2, 5'd11, 5'd1, 1'b0, 1'b1, 1'b0, 32'h0);
        bus.flush_i = 1'b1;
        #1;
        checks++; if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL fl_ready got %0b want 0", bus.ready_o); end
        tick();
        checks++; if (bus.valid_o !== 1'b0 || bus.rd_o !== 5'd0) begin errors++; $display("FAIL fl_bubble got v%0b rd%0d want v0 rd0", bus.valid_o, bus.rd_o); end
        checks++; if (bus.stall_cnt_o !== 16'd1) begin errors++; $display("FAIL fl_cnt got %0d want 1", bus.stall_cnt_o); end
        bus.flush_i = 1'b0;
        #1;
        tick();
        checks++; if (bus.valid_o !== 1'b1 || bus.mux1_o !== 2'b01) begin errors++; $display("FAIL fl_resume got v%0b mux1 %0b want v1 01", bus.valid_o, bus.mux1_o); end
        drive(1'b1, 5'd20, 5'd21, 5'd22, 5'd4, 1'b0, 1'b1, 1'b0, 32'h0);
        bus.flush_i = 1'b1;
        #1;
        checks++; if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL fl_nohaz_ready got %0b want 0", bus.ready_o); end
        tick();
        checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL fl_nohaz_valid got %0b want 0", bus.valid_o); end
        bus.flush_i = 1'b0;
        #1;
    endtask

    task automatic test_reset_mid_stall;
        idle();
        drive(1'b1, 5'd1, 5'd0, 5'd5, 5'd8, 1'b1, 1'b1, 1'b1, 32'h0);
        tick();
        drive(1'b1, 5'd5, 5'd2, 5'd11, 5'd1, 1'b0, 1'b1, 1'b0, 32'h0);
        rst_n = 1'b0;
        #1;
        checks++; if (bus.valid_o !== 1'b0 || bus.rd_o !== 5'd0 || bus.rd_we_o !== 1'b0) begin errors++; $display("FAIL ar_out got v%0b rd%0d we%0b want all 0", bus.valid_o, bus.rd_o, bus.rd_we_o); end
        checks++; if (bus.stall_cnt_o !== 16'd0 || bus.ready_o !== 1'b0) begin errors++; $display("FAIL ar_cnt_ready got %0d/%0b want 0/0", bus.stall_cnt_o, bus.ready_o); end
        @(negedge clk_25mhz);
        rst_n = 1'b1;
        #1;
        checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL ar_ready got %0b want 1", bus.ready_o); end
        tick();
        checks++; if (bus.valid_o !== 1'b1 || bus.rd_o !== 5'd11 || bus.mux1_o !== 2'b00) begin errors++; $display("FAIL ar_issue got v%0b rd%0d mux1 %0b want v1 rd11 00", bus.valid_o, bus.rd_o, bus.mux1_o); end
    endtask

    task automatic test_saturate;
        force dut.e_valid_q   = 1'b1;
        force dut.e_rd_we_q   = 1'b1;
        force dut.e_is_load_q = 1'b1;
        force dut.e_rd_q      = 5'd5;
        drive(1'b1, 5'd5, 5'd2, 5'd11, 5'd1, 1'b0, 1'b1, 1'b0, 32'h0);
        checks++; if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL sat_ready got %0b want 0", bus.ready_o); end
        repeat (65534) tick();
        checks++; if (bus.stall_cnt_o !== 16'hFFFE) begin errors++; $display("FAIL sat_fffe got %0h want fffe", bus.stall_cnt_o); end
        tick();
        checks++; if (bus.stall_cnt_o !== 16'hFFFF) begin errors++; $display("FAIL sat_ffff got %0h want ffff", bus.stall_cnt_o); end
        tick();
        tick();
        checks++; if (bus.stall_cnt_o !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %0h want ffff", bus.stall_cnt_o); end
        release dut.e_valid_q;
        release dut.e_rd_we_q;
        release dut.e_is_load_q;
        release dut.e_rd_q;
        idle();
    endtask

    initial begin
        test_reset();
        test_ex_forward();
        test_mem_forward();
        test_load_use();
        test_x0_imm();
        test_flush();
        test_reset_mid_stall();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
